johnson_seq_ctrl: RTL and testbench
===================================

// Module: johnson_seq_ctrl
// PURPOSE
//   WIDTH-stage Johnson (twisted-ring) counter, built on the team's DFF cell, plus its decode stage.
//   Steps through 2*WIDTH states in either direction, with synchronous clear and parallel load.
//   Decodes the ring into a one-hot phase vector, a binary phase index and a terminal-count strobe.
//   Detects and self-corrects illegal (non-Johnson) ring contents.
//   Sits directly above the DFF cells and feeds downstream phase/sequencer logic.
// PARAMETERS
//   WIDTH  4  number of ring stages; legal range 2..16; sequence length is 2*WIDTH
//   IDX_W  3  width of state_idx; must satisfy 2**IDX_W >= 2*WIDTH
// PORTS
//   clk        in   1        clock; all state updates on its rising edge
//   rst        in   1        synchronous, active-high reset
//   en         in   1        advance one state this cycle
//   dir        in   1        0 = count up, 1 = count down
//   clr        in   1        synchronous clear to state 0; also clears err
//   ld         in   1        parallel load of ld_val into the ring
//   ld_val     in   WIDTH    value to load; may be illegal
//   q          out  WIDTH    ring register contents
//   q_bar      out  WIDTH    bitwise ~q
//   state_idx  out  IDX_W    phase index 0..2*WIDTH-1; 0 when q is illegal
//   onehot     out  2*WIDTH  onehot[state_idx] = 1; all-zero when q is illegal
//   tc         out  1        terminal-count strobe
//   err        out  1        sticky illegal-state flag
// BEHAVIOUR
//   Clock and reset: one clock domain (clk); reset is synchronous and active-high.
//   Reset values: q = 0, q_bar = all-ones, err = 0.
//     Decode outputs follow from q = 0: state_idx = 0, onehot = 1, tc = en & dir.
//   Next-state priority per edge: rst > clr > ld > illegal-correct > en > hold.
//   Up step:   q <= {q[WIDTH-2:0], ~q[WIDTH-1]}
//     WIDTH=4: 0000 -> 0001 -> 0011 -> 0111 -> 1111 -> 1110 -> 1100 -> 1000 -> 0000
//   Down step: q <= {~q[0], q[WIDTH-1:1]}; exact reverse of the up sequence.
//   Legal q: exactly the 2*WIDTH patterns of the up sequence; any other pattern is illegal.
//   Index decode (p = popcount(q)), combinational from q, zero latency:
//     q[WIDTH-1] = 0 -> idx = p
//     q[WIDTH-1] = 1 -> idx = 2*WIDTH - p
//   tc (combinational, zero latency):
//     = en & ~dir when idx = 2*WIDTH-1
//     = en &  dir when idx = 0
//     Forced to 0 when q is illegal, or when rst, clr or ld is asserted.
//   Illegal-state correction:
//     If q is illegal at an edge and no rst/clr/ld, then q <= 0 whatever en is (self-correct in 1 cycle).
//   err:
//     Set on any edge where q is illegal, unless rst or clr is asserted on that edge.
//     Stays set until rst or clr.
//   ld: ld_val is taken verbatim, even if illegal.
//     An illegal loaded value is visible for exactly one cycle, then corrected on the next edge.
//   Simultaneous events:
//     clr with ld -> clr wins, ld_val ignored.
//     ld with en -> load only, no step.
//     rst mid-sequence -> q = 0 on that edge; no tc pulse for that cycle.
//   dir may change on any cycle; the step uses the dir value sampled at that edge.
//   Wrap-around is natural: the step after idx 2*WIDTH-1 (up) is idx 0, and vice versa for down.
// TESTING
//   (WIDTH=4 for all scenarios)
//   1 rst then en=1 dir=0 for 9 cycles
//     -> q: 0001,0011,0111,1111,1110,1100,1000,0000,0001
//     -> state_idx 1..7,0,1
//     -> tc high only in the cycle with q=1000
//   2 From q=0000, en=1 dir=1 for 2 cycles
//     -> q = 1000 then 1100; state_idx = 7 then 6
//     -> tc high in the first cycle (idx 0, down)
//   3 ld=1 ld_val=0101 for 1 cycle, then en=0
//     -> q=0101 for 1 cycle, onehot=0, state_idx=0
//     -> next edge q=0000 and err=1; err stays 1 until clr=1, after which err=0
//   4 At q=0111: clr=1 and ld=1 (ld_val=1110) together -> q=0000, err=0
//     Then ld=1 and en=1 (ld_val=1110) together -> q=1110, state_idx=5 (load wins, no step)
//   5 At q=1100 with en=1: assert rst for 1 cycle -> q=0000, tc=0 that cycle
//     Then en=1 dir=0 -> q resumes 0001
//   6 Random en/dir/ld/clr for 10k cycles against a reference model
//     -> state_idx agrees with q every cycle
//     -> onehot == 1 << state_idx whenever q is legal
//     -> q_bar == ~q always

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// Johnson (twisted-ring) counter with up/down stepping, clear, parallel load and phase decode.
// Latency: ring updates one cycle after the controlling inputs; decode outputs and tc are combinational from q.
// Backpressure: none; en gates advancement, and illegal ring contents self-correct on the next edge.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (q = 0, err = 0)
//   en         advance one state this cycle
//   dir        0 = count up, 1 = count down
//   clr        synchronous clear to state 0; also clears err
//   ld         parallel load of ld_val (taken verbatim, even if illegal)
//   ld_val     value to load
//   q / q_bar  ring contents and their complement
//   state_idx  phase index 0..2*WIDTH-1 (0 when q is illegal)
//   onehot     one-hot phase (all-zero when q is illegal)
//   tc         terminal-count strobe for the current direction
//   err        sticky flag: ring held an illegal pattern at some edge
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 clr,
  input  logic                 ld,
  input  logic [WIDTH-1:0]     ld_val,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     q_bar,
  output logic [IDX_W-1:0]     state_idx,
  output logic [2*WIDTH-1:0]   onehot,
  output logic                 tc,
  output logic                 err
);

  localparam int SEQ_LEN = 2 * WIDTH;

  if (WIDTH < 2 || WIDTH > 16 || (1 << IDX_W) < SEQ_LEN) begin : g_bad_param
    $error("johnson_seq_ctrl: WIDTH must be 2..16 and 2**IDX_W >= 2*WIDTH");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [4:0]       pop;
  logic [4:0]       trans;
  logic             legal;
  logic [5:0]       idx_full;

  // A Johnson pattern is a single run of ones against a single run of zeros,
  // so any legal ring has at most one boundary between adjacent bits.
  always_comb begin
    pop   = '0;
    trans = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + 5'(q_q[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      trans = trans + 5'(q_q[i] ^ q_q[i+1]);
    end
    legal = (trans <= 5'd1);
  end

  // Filling phase (MSB clear) counts ones; draining phase counts back down from 2*WIDTH.
  always_comb begin
    if (q_q[WIDTH-1]) begin
      idx_full = 6'(SEQ_LEN) - 6'(pop);
    end else begin
      idx_full = 6'(pop);
    end
  end

  always_comb begin
    q_d   = q_q;
    err_d = err_q;
    if (clr) begin
      q_d   = '0;
      err_d = 1'b0;
    end else begin
      if (!legal) begin
        err_d = 1'b1;
      end
      if (ld) begin
        q_d = ld_val;
      end else if (!legal) begin
        q_d = '0;
      end else if (en) begin
        if (dir) begin
          q_d = {~q_q[0], q_q[WIDTH-1:1]};
        end else begin
          q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign q         = q_q;
  assign q_bar     = ~q_q;
  assign err       = err_q;
  assign state_idx = legal ? IDX_W'(idx_full) : '0;
  assign onehot    = legal ? (SEQ_LEN'(1) << idx_full) : '0;

  // tc only fires when this edge would really wrap; any higher-priority action suppresses it.
  assign tc = legal & ~rst & ~clr & ~ld & en &
              (dir ? (idx_full == 6'd0) : (idx_full == 6'(SEQ_LEN - 1)));

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
module tb_johnson_seq_ctrl;
  localparam int W  = 4;
  localparam int IW = 3;
  localparam int N  = 2 * W;

  logic          clk = 1'b0;
  logic          rst, en, dir, clr, ld;
  logic [W-1:0]  ld_val;
  logic [W-1:0]  q, q_bar;
  logic [IW-1:0] state_idx;
  logic [N-1:0]  onehot;
  logic          tc, err;

  johnson_seq_ctrl #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .ld(ld), .ld_val(ld_val),
    .q(q), .q_bar(q_bar), .state_idx(state_idx), .onehot(onehot), .tc(tc), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  logic [W-1:0] m_q;
  logic         m_err;

  // k-th pattern of the up sequence: k ones filling from the bottom, then zeros filling from the bottom.
  function automatic logic [W-1:0] pat(input int k);
    int v;
    if (k <= W) v = (1 << k) - 1;
    else        v = ((1 << W) - 1) ^ ((1 << (k - W)) - 1);
    return v[W-1:0];
  endfunction

  // Position of v in the up sequence, or -1 if v is not a sequence member.
  function automatic int idx_of(input logic [W-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (pat(k) === v) return k;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: advance by sequence position, not by bit manipulation.
  always @(posedge clk) begin
    if (rst || clr) begin
      m_q   <= '0;
      m_err <= 1'b0;
    end else begin
      if (idx_of(m_q) < 0) m_err <= 1'b1;
      if (ld)                     m_q <= ld_val;
      else if (idx_of(m_q) < 0)   m_q <= '0;
      else if (en)                m_q <= pat((idx_of(m_q) + (dir ? N - 1 : 1)) % N);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin : cmp
    int           k;
    bit           leg;
    logic [W-1:0] nq;
    logic [N-1:0] eoh;
    logic [IW-1:0] eidx;
    bit           etc;
    if (chk_on) begin
      k    = idx_of(m_q);
      leg  = (k >= 0);
      nq   = ~m_q;
      eoh  = leg ? (N'(1) << k) : '0;
      eidx = leg ? IW'(k) : '0;
      etc  = leg && !rst && !clr && !ld && en && (dir ? (k == 0) : (k == N - 1));
      check("model_q", q, m_q);
      check("model_q_bar", q_bar, nq);
      check("model_idx", state_idx, eidx);
      check("model_onehot", onehot, eoh);
      check("model_tc", tc, etc);
      check("model_err", err, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [W-1:0] s1_q [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                             4'b1100, 4'b1000, 4'b0000, 4'b0001};
  int           s1_i [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; clr = 1'b0; ld = 1'b0; ld_val = '0;
    step();
    chk_on = 1'b1;
    // reset state (rst still asserted, so tc must be 0 regardless)
    check("rst_q", q, 4'b0000);
    check("rst_q_bar", q_bar, 4'b1111);
    check("rst_err", err, 1'b0);
    check("rst_idx", state_idx, 0);
    check("rst_onehot", onehot, 8'b0000_0001);

    // scenario 1: count up through a full wrap
    rst = 1'b0; en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      check("s1_q", q, s1_q[i]);
      check("s1_idx", state_idx, s1_i[i]);
      check("s1_tc", tc, (s1_q[i] == 4'b1000));
    end

    // scenario 2: count down from 0
    rst = 1'b1; en = 1'b0; step();
    rst = 1'b0; en = 1'b1; dir = 1'b1; #1;
    check("s2_tc_idx0_down", tc, 1'b1);
    step();
    check("s2_q1", q, 4'b1000);
    check("s2_idx1", state_idx, 7);
    check("s2_tc_idx7_down", tc, 1'b0);
    step();
    check("s2_q2", q, 4'b1100);
    check("s2_idx2", state_idx, 6);

    // scenario 3: illegal load, self-correction, sticky err
    en = 1'b0; ld = 1'b1; ld_val = 4'b0101; step();
    ld = 1'b0; #1;
    check("s3_q_illegal", q, 4'b0101);
    check("s3_onehot_illegal", onehot, 8'h00);
    check("s3_idx_illegal", state_idx, 0);
    check("s3_err_before", err, 1'b0);
    step();
    check("s3_q_fixed", q, 4'b0000);
    check("s3_err_set", err, 1'b1);
    step(); step();
    check("s3_err_sticky", err, 1'b1);
    clr = 1'b1; step(); clr = 1'b0;
    check("s3_err_clr", err, 1'b0);

    // scenario 4: set err again, walk to 0111, then clr+ld, then ld+en
    ld = 1'b1; ld_val = 4'b1010; step(); ld = 1'b0; step();
    en = 1'b1; dir = 1'b0; step(); step(); step();
    check("s4_q_0111", q, 4'b0111);
    check("s4_err_pre", err, 1'b1);
    en = 1'b0; clr = 1'b1; ld = 1'b1; ld_val = 4'b1110; step();
    check("s4_clr_wins_q", q, 4'b0000);
    check("s4_clr_wins_err", err, 1'b0);
    clr = 1'b0; ld = 1'b1; en = 1'b1; step();
    check("s4_ld_wins_q", q, 4'b1110);
    check("s4_ld_wins_idx", state_idx, 5);

    // scenario 5: rst mid-sequence suppresses tc and clears the ring
    ld = 1'b0; en = 1'b1; dir = 1'b0; step();
    check("s5_q_1100", q, 4'b1100);
    rst = 1'b1; #1;
    check("s5_tc_rst", tc, 1'b0);
    step();
    check("s5_q_rst", q, 4'b0000);
    rst = 1'b0; step();
    check("s5_q_resume", q, 4'b0001);
    for (int i = 0; i < 6; i++) step();
    check("s5_q_1000", q, 4'b1000);
    rst = 1'b1; #1;
    check("s5_tc_rst_at_wrap", tc, 1'b0);
    step();
    rst = 1'b0;

    // scenario 6: randomized traffic against the model
    for (int i = 0; i < 10000; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      clr    = ($urandom_range(0, 31) == 0);
      ld     = ($urandom_range(0, 15) == 0);
      en     = ($urandom_range(0, 3) != 0);
      dir    = $urandom_range(0, 1) == 1;
      ld_val = ($urandom_range(0, 1) == 1) ? pat($urandom_range(0, N - 1)) : W'($urandom);
      step();
    end

    rst = 1'b0; clr = 1'b0; ld = 1'b0; en = 1'b0;
    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
